// File: rtl/dict_arbiter_if.sv
// Bundle of requester-side and dictionary-side signals for dict_arbiter.
// The arbiter uses the slave modport; whatever drives requests and models the dictionary uses master.
interface dict_arbiter_if #(
  parameter int NREQ       = 2,
  parameter int IDXW       = 4,
  parameter int KEY_BITS   = 64,
  parameter int VALUE_BITS = 32
);
  logic [NREQ-1:0]            i_req_valid;
  logic [NREQ*3-1:0]          i_req_op;
  logic [NREQ*KEY_BITS-1:0]   i_req_key;
  logic [NREQ*IDXW-1:0]       i_req_index;
  logic [NREQ*VALUE_BITS-1:0] i_req_value;
  logic [NREQ-1:0]            o_rsp_valid;
  logic                       o_rsp_err;
  logic [VALUE_BITS-1:0]      o_rsp_value;
  logic [IDXW-1:0]            o_rsp_index;
  logic                       o_dict_en;
  logic                       o_dict_ready;
  logic [2:0]                 o_dict_op;
  logic [KEY_BITS-1:0]        o_dict_key;
  logic [IDXW-1:0]            o_dict_index;
  logic [VALUE_BITS-1:0]      o_dict_value;
  logic                       i_dict_done;
  logic [VALUE_BITS-1:0]      i_dict_value;
  logic [IDXW-1:0]            i_dict_index;
  logic                       o_busy;

  modport slave (
    input  i_req_valid, i_req_op, i_req_key, i_req_index, i_req_value,
    input  i_dict_done, i_dict_value, i_dict_index,
    output o_rsp_valid, o_rsp_err, o_rsp_value, o_rsp_index,
    output o_dict_en, o_dict_ready, o_dict_op, o_dict_key, o_dict_index, o_dict_value,
    output o_busy
  );

  modport master (
    output i_req_valid, i_req_op, i_req_key, i_req_index, i_req_value,
    output i_dict_done, i_dict_value, i_dict_index,
    input  o_rsp_valid, o_rsp_err, o_rsp_value, o_rsp_index,
    input  o_dict_en, o_dict_ready, o_dict_op, o_dict_key, o_dict_index, o_dict_value,
    input  o_busy
  );
endinterface

// File: rtl/dict_arbiter.sv
// Round-robin arbiter sharing one string->integer dictionary between NREQ requesters.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP, with a timeout in WAIT.
module dict_arbiter #(
  parameter int NREQ       = 2,
  parameter int ENTRIES    = 10,
  parameter int KEY_BITS   = 64,
  parameter int VALUE_BITS = 32,
  parameter int TIMEOUT    = 15,
  localparam int IDXW      = $clog2(ENTRIES),
  localparam int TOW       = $clog2(TIMEOUT + 1)
) (
  input logic           i_clk,
  input logic           i_rst,
  dict_arbiter_if.slave bus
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         rr_q, rr_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [2:0]            op_q, op_d;
  logic [KEY_BITS-1:0]   key_q, key_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [VALUE_BITS-1:0] val_q, val_d;
  logic [TOW-1:0]        cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [VALUE_BITS-1:0] rval_q, rval_d;
  logic [IDXW-1:0]       ridx_q, ridx_d;

  logic                  req_found;
  logic [GW-1:0]         win;
  logic [GW-1:0]         cand;
  logic [NREQ-1:0]       rsp_valid;

  // Round-robin search: start just after the last winner and take the first valid requester.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    req_found = 1'b0;
    win       = rr_q;
    cand      = rr_q;
    for (int off = 1; off <= NREQ; off++) begin
      cand = GW'((int'(rr_q) + off) % NREQ);
      if (!req_found && bus.i_req_valid[cand]) begin
        req_found = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    op_d    = op_q;
    key_d   = key_q;
    idx_d   = idx_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rval_d  = rval_q;
    ridx_d  = ridx_q;

    case (state_q)
      S_IDLE: begin
        if (req_found) begin
          grant_d = win;
          rr_d    = win;
          op_d    = bus.i_req_op[3*win +: 3];
          key_d   = bus.i_req_key[KEY_BITS*win +: KEY_BITS];
          idx_d   = bus.i_req_index[IDXW*win +: IDXW];
          val_d   = bus.i_req_value[VALUE_BITS*win +: VALUE_BITS];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_dict_done) begin
          rval_d  = bus.i_dict_value;
          ridx_d  = bus.i_dict_index;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + TOW'(1);
          // Counter reaching TIMEOUT means TIMEOUT full WAIT cycles have elapsed without done.
          if (cnt_q == TOW'(TIMEOUT - 1)) begin
            rval_d  = '0;
            ridx_d  = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The command registers are cleared on reset so the dictionary port shows zeros until the first grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      rr_q    <= GW'(NREQ - 1);
      grant_q <= '0;
      op_q    <= '0;
      key_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rval_q  <= '0;
      ridx_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      op_q    <= op_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rval_q  <= rval_d;
      ridx_q  <= ridx_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid[grant_q] = 1'b1;
  end

  // Strobe and busy decode straight from the state register, so reset drops them asynchronously.
  assign bus.o_rsp_valid  = rsp_valid;
  assign bus.o_rsp_err    = err_q;
  assign bus.o_rsp_value  = rval_q;
  assign bus.o_rsp_index  = ridx_q;
  assign bus.o_dict_en    = 1'b1;
  assign bus.o_dict_ready = (state_q == S_ISSUE);
  assign bus.o_dict_op    = op_q;
  assign bus.o_dict_key   = key_q;
  assign bus.o_dict_index = idx_q;
  assign bus.o_dict_value = val_q;
  assign bus.o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dict_arbiter.sv
// Directed bench for dict_arbiter: a vector table of transactions plus hand sequences
// for latched commands, ignored done, and reset in flight.
module tb_dict_arbiter;

  localparam int NREQ = 2;
  localparam int IDXW = 4;
  localparam int KB   = 64;
  localparam int VB   = 32;
  localparam int TOUT = 15;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  dict_arbiter_if #(.NREQ(NREQ), .IDXW(IDXW), .KEY_BITS(KB), .VALUE_BITS(VB)) bus ();

  dict_arbiter #(
    .NREQ(NREQ), .ENTRIES(10), .KEY_BITS(KB), .VALUE_BITS(VB), .TIMEOUT(TOUT)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]    valid;
    logic [2:0]    op;
    int            delay;   // cycles from ready to done; 0 = never
    logic [VB-1:0] dv;
    logic [3:0]    di;
    int            grant;
    logic          err;
    logic [VB-1:0] ev;
    logic [3:0]    ei;
    int            lat;     // cycles from ready to o_rsp_valid
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [KB-1:0] key_of(input int v, input int n);
    return {24'h445550, 8'(v), 8'(n), 24'h0};
  endfunction

  function automatic logic [VB-1:0] val_of(input int v, input int n);
    return 32'h1000_0000 + VB'(v * 16 + n);
  endfunction

  function automatic logic [IDXW-1:0] idx_of(input int v, input int n);
    return IDXW'(v + n + 1);
  endfunction

  task automatic set_fields(input int v, input logic [2:0] op);
    for (int n = 0; n < NREQ; n++) begin
      bus.i_req_op[3*n +: 3]        = op ^ 3'(n);
      bus.i_req_key[KB*n +: KB]     = key_of(v, n);
      bus.i_req_value[VB*n +: VB]   = val_of(v, n);
      bus.i_req_index[IDXW*n +: IDXW] = idx_of(v, n);
    end
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus.o_dict_ready && cyc < 20);
  endtask

  // Starts in the ISSUE cycle; plays the dictionary and returns at the RESP cycle.
  task automatic do_txn(input int delay, input logic [VB-1:0] dv, input logic [3:0] di,
                        output logic [1:0] rv, output int lat, output int rdy_cnt);
    lat = 0; rdy_cnt = 1; rv = '0;
    bus.i_dict_value = dv;
    bus.i_dict_index = di;
    while (lat < 40) begin
      step();
      lat++;
      if (bus.o_dict_ready) rdy_cnt++;
      if (bus.o_rsp_valid != '0) begin
        rv = bus.o_rsp_valid;
        bus.i_dict_done = 1'b0;
        break;
      end
      bus.i_dict_done = (delay != 0 && lat == delay);
    end
    bus.i_dict_done = 1'b0;
  endtask

  initial begin
    int cyc, lat, rdy;
    logic [1:0] rv;

    vecs[0] = '{2'b01, 3'd0, 2, 32'd5,          4'd2, 0, 1'b0, 32'd5,          4'd2, 3};
    vecs[1] = '{2'b11, 3'd1, 1, 32'hDEADBEEF,   4'd3, 1, 1'b0, 32'hDEADBEEF,   4'd3, 2};
    vecs[2] = '{2'b11, 3'd2, 3, 32'h0000_1234,  4'd7, 0, 1'b0, 32'h0000_1234,  4'd7, 4};
    vecs[3] = '{2'b11, 3'd3, 1, 32'hCAFE_0001,  4'd9, 1, 1'b0, 32'hCAFE_0001,  4'd9, 2};
    vecs[4] = '{2'b10, 3'd1, 0, 32'h5555_5555,  4'd5, 1, 1'b1, 32'h0,          4'd0, TOUT + 1};
    vecs[5] = '{2'b10, 3'd4, 1, 32'd77,         4'd9, 1, 1'b0, 32'd77,         4'd9, 2};
    vecs[6] = '{2'b01, 3'd7, 4, 32'hA5A5_0F0F,  4'd1, 0, 1'b0, 32'hA5A5_0F0F,  4'd1, 5};

    bus.i_req_valid  = '0;
    bus.i_req_op     = '0;
    bus.i_req_key    = '0;
    bus.i_req_index  = '0;
    bus.i_req_value  = '0;
    bus.i_dict_done  = 1'b0;
    bus.i_dict_value = '0;
    bus.i_dict_index = '0;

    #1;
    check("reset_dict_en", 64'(bus.o_dict_en), 64'd1);
    step(); step();
    check("reset_busy",      64'(bus.o_busy),       64'd0);
    check("reset_ready",     64'(bus.o_dict_ready), 64'd0);
    check("reset_rsp_valid", 64'(bus.o_rsp_valid),  64'd0);
    check("reset_rsp_err",   64'(bus.o_rsp_err),    64'd0);
    check("reset_rsp_value", 64'(bus.o_rsp_value),  64'd0);
    check("reset_dict_key",  64'(bus.o_dict_key),   64'd0);
    check("reset_dict_op",   64'(bus.o_dict_op),    64'd0);
    i_rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      set_fields(i, vecs[i].op);
      bus.i_req_valid = vecs[i].valid;
      wait_ready(cyc);
      check($sformatf("v%0d_ready_gap", i), 64'(cyc), 64'(i == 0 ? 1 : 2));
      check($sformatf("v%0d_busy", i), 64'(bus.o_busy), 64'd1);
      check($sformatf("v%0d_dict_op", i), 64'(bus.o_dict_op), 64'(vecs[i].op ^ 3'(vecs[i].grant)));
      check($sformatf("v%0d_dict_key", i), 64'(bus.o_dict_key), 64'(key_of(i, vecs[i].grant)));
      check($sformatf("v%0d_dict_val", i), 64'(bus.o_dict_value), 64'(val_of(i, vecs[i].grant)));
      check($sformatf("v%0d_dict_idx", i), 64'(bus.o_dict_index), 64'(idx_of(i, vecs[i].grant)));
      do_txn(vecs[i].delay, vecs[i].dv, vecs[i].di, rv, lat, rdy);
      check($sformatf("v%0d_rsp_valid", i), 64'(rv), 64'(2'b01 << vecs[i].grant));
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_ready_cycles", i), 64'(rdy), 64'd1);
      check($sformatf("v%0d_rsp_err", i), 64'(bus.o_rsp_err), 64'(vecs[i].err));
      check($sformatf("v%0d_rsp_value", i), 64'(bus.o_rsp_value), 64'(vecs[i].ev));
      check($sformatf("v%0d_rsp_index", i), 64'(bus.o_rsp_index), 64'(vecs[i].ei));
      bus.i_req_valid = '0;
    end

    // done while idle must not start or complete anything
    bus.i_dict_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("idle_done_busy%0d", k), 64'(bus.o_busy), 64'd0);
      check($sformatf("idle_done_rsp%0d", k), 64'(bus.o_rsp_valid), 64'd0);
    end
    bus.i_dict_done = 1'b0;
    check("rsp_value_held", 64'(bus.o_rsp_value), 64'hA5A5_0F0F);

    // requester 1 changes its command after the grant
    set_fields(8, 3'd2);
    bus.i_req_valid = 2'b10;
    wait_ready(cyc);
    check("latch_ready_seen", 64'(bus.o_dict_ready), 64'd1);
    bus.i_req_op[5:3]     = 3'd6;
    bus.i_req_key[127:64] = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check("latch_op_wait",  64'(bus.o_dict_op),  64'(3'd2 ^ 3'd1));
    check("latch_key_wait", 64'(bus.o_dict_key), 64'(key_of(8, 1)));
    bus.i_dict_value = 32'h0BAD_F00D;
    bus.i_dict_index = 4'd6;
    bus.i_dict_done  = 1'b1;
    step();
    bus.i_dict_done = 1'b0;
    check("latch_rsp_valid", 64'(bus.o_rsp_valid), 64'b10);
    check("latch_rsp_value", 64'(bus.o_rsp_value), 64'h0BAD_F00D);
    check("latch_key_after", 64'(bus.o_dict_key), 64'(key_of(8, 1)));
    bus.i_req_valid = '0;

    // reset during a transaction, then the pointer restarts at requester 0
    set_fields(9, 3'd5);
    bus.i_req_valid = 2'b11;
    wait_ready(cyc);
    check("rst_pre_key", 64'(bus.o_dict_key), 64'(key_of(9, 0)));
    step();
    #2 i_rst = 1'b1;
    #1;
    check("rst_async_busy",  64'(bus.o_busy),       64'd0);
    check("rst_async_ready", 64'(bus.o_dict_ready), 64'd0);
    check("rst_dict_en",     64'(bus.o_dict_en),    64'd1);
    bus.i_dict_done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("rst_no_rsp%0d", k), 64'(bus.o_rsp_valid), 64'd0);
    end
    bus.i_dict_done = 1'b0;
    i_rst = 1'b0;
    wait_ready(cyc);
    check("rst_regrant_gap", 64'(cyc), 64'd1);
    check("rst_regrant_key", 64'(bus.o_dict_key), 64'(key_of(9, 0)));
    do_txn(1, 32'h1111_2222, 4'd4, rv, lat, rdy);
    check("rst_regrant_rsp", 64'(rv), 64'b01);
    check("rst_regrant_val", 64'(bus.o_rsp_value), 64'h1111_2222);
    bus.i_req_valid = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
